// File: rtl/mont_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mont_arbiter: round-robin arbiter sharing one Montgomery multiplier core
// among N_REQ requesters, with start/done sequencing and a completion watchdog.
// Revision: 1.0
// ----------------------------------------------------------------------------
module mont_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 381,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ*WIDTH-1:0] req_m,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_error,
  output logic                   busy,
  output logic                   fault,
  output logic                   core_start,
  output logic [WIDTH-1:0]       core_a,
  output logic [WIDTH-1:0]       core_b,
  output logic [WIDTH-1:0]       core_m,
  input  logic [WIDTH-1:0]       core_result,
  input  logic                   core_done
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] pick;
  logic [PTR_W:0]   idx;
  logic             found;
  logic [WD_W-1:0]  wd_cnt;
  logic             pend_fault;
  logic             wd_expired;

  // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(N_REQ))
        idx = idx - (PTR_W+1)'(N_REQ);
      if (!found && req_valid[idx[PTR_W-1:0]]) begin
        found = 1'b1;
        pick  = idx[PTR_W-1:0];
      end
    end
  end

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    busy       = 1'b1;
    fault      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (found) begin
          req_ready = N_REQ'(1) << pick;
          state_nx  = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_nx   = S_WAIT;
      end
      S_WAIT: begin
        if (core_done || wd_expired)
          state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = N_REQ'(1) << grant;
        state_nx  = pend_fault ? S_FAULT : S_IDLE;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      grant      <= '0;
      wd_cnt     <= '0;
      pend_fault <= 1'b0;
      core_a     <= '0;
      core_b     <= '0;
      core_m     <= '0;
      rsp_result <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant  <= pick;
            rr_ptr <= (pick == PTR_W'(N_REQ-1)) ? '0 : pick + 1'b1;
            core_a <= req_a[pick*WIDTH +: WIDTH];
            core_b <= req_b[pick*WIDTH +: WIDTH];
            core_m <= req_m[pick*WIDTH +: WIDTH];
          end
        end
        S_START: wd_cnt <= '0;
        S_WAIT: begin
          // A done arriving on the last allowed cycle still counts as success.
          if (core_done) begin
            rsp_result <= core_result;
            rsp_error  <= 1'b0;
          end else if (wd_expired) begin
            rsp_result <= '0;
            rsp_error  <= 1'b1;
            pend_fault <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mont_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mont_arbiter: randomized scoreboard bench for mont_arbiter with a stub core.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_mont_arbiter;
  localparam int N  = 4;
  localparam int W  = 381;
  localparam int TO = 400;

  localparam int PH_IDLE  = 0;
  localparam int PH_START = 1;
  localparam int PH_WAIT  = 2;
  localparam int PH_RESP  = 3;
  localparam int PH_FAULT = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N*W-1:0] req_m;
  logic [W-1:0]   rsp_result;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic [W-1:0]   core_m;
  logic [W-1:0]   core_result;
  logic           rsp_error;
  logic           busy;
  logic           fault;
  logic           core_start;
  logic           core_done;

  mont_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_m(req_m),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_error(rsp_error),
    .busy(busy), .fault(fault), .core_start(core_start),
    .core_a(core_a), .core_b(core_b), .core_m(core_m),
    .core_result(core_result), .core_done(core_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int           idx;
    logic [W-1:0] res;
  } exp_t;

  exp_t         sb[$];
  int           order_log[$];
  int           m_ph = PH_IDLE;
  int           m_ptr = 0;
  int           m_wd = 0;
  bit           m_to = 1'b0;
  logic [W-1:0] m_a, m_b, m_m;
  logic [W-1:0] m_last = '0;
  bit           m_last_err = 1'b0;

  int lat_cfg    = 0;     // 0: random latency, >0: fixed, <0: never completes
  bit spur_now   = 1'b0;
  bit spur_start = 1'b0;

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v = '0;
    for (int k = 0; k < W; k += 32) v = {v[W-33:0], $urandom};
    return v;
  endfunction

  function automatic logic [W-1:0] core_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    return a * b + (m << 1) + W'(2);
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Stub multiplier core: done pulses L cycles after the START cycle.
  initial begin : stub_core
    int cnt;
    bit active;
    logic [W-1:0] sa, sbv, sm;
    cnt = 0;
    active = 1'b0;
    core_done = 1'b0;
    core_result = '0;
    forever begin
      @(posedge clk);
      #1;
      core_done   = 1'b0;
      core_result = rand_w();
      if (reset) begin
        active = 1'b0;
        cnt    = 0;
      end else if (core_start) begin
        sa = core_a; sbv = core_b; sm = core_m;
        active = (lat_cfg >= 0);
        cnt = (lat_cfg == 0) ? int'($urandom_range(1, 30)) : lat_cfg;
        if (spur_start) begin
          core_done  = 1'b1;
          spur_start = 1'b0;
        end
      end else if (active) begin
        cnt--;
        if (cnt <= 0) begin
          core_done   = 1'b1;
          core_result = core_fn(sa, sbv, sm);
          active      = 1'b0;
        end
      end else if (spur_now) begin
        core_done = 1'b1;
        spur_now  = 1'b0;
      end
    end
  end

  // Monitor: reference model of the arbiter's observable behaviour plus scoreboard.
  initial begin : monitor
    int p;
    exp_t e;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    logic [W-1:0] exp_res;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("rst_outputs", W'({req_ready, rsp_valid, rsp_error, busy, fault, core_start}), '0);
        chk("rst_core_a", core_a, '0);
        chk("rst_core_b", core_b, '0);
        chk("rst_core_m", core_m, '0);
        chk("rst_rsp_result", rsp_result, '0);
        m_ph = PH_IDLE; m_ptr = 0; m_wd = 0; m_to = 1'b0;
        m_last = '0; m_last_err = 1'b0;
        sb.delete();
      end else begin
        p = rr_pick(req_valid, m_ptr);
        exp_rdy = '0;
        if (m_ph == PH_IDLE && p >= 0) exp_rdy[p] = 1'b1;
        chk("req_ready", W'(req_ready), W'(exp_rdy));
        chk("core_start", W'(core_start), W'(m_ph == PH_START));
        chk("busy", W'(busy), W'(m_ph != PH_IDLE));
        chk("fault", W'(fault), W'(m_ph == PH_FAULT));
        if (m_ph == PH_START || m_ph == PH_WAIT) begin
          chk("core_a", core_a, m_a);
          chk("core_b", core_b, m_b);
          chk("core_m", core_m, m_m);
        end
        if (m_ph == PH_RESP) begin
          if (sb.size() == 0) begin
            fail_now("sb_underflow");
            e.idx = 0;
            e.res = '0;
          end else begin
            e = sb.pop_front();
          end
          exp_rv = '0;
          exp_rv[e.idx] = 1'b1;
          exp_res = m_to ? '0 : e.res;
          chk("rsp_valid", W'(rsp_valid), W'(exp_rv));
          chk("rsp_result", rsp_result, exp_res);
          chk("rsp_error", W'(rsp_error), W'(m_to));
          m_last = exp_res;
          m_last_err = m_to;
        end else begin
          chk("rsp_valid_idle", W'(rsp_valid), '0);
          chk("rsp_result_hold", rsp_result, m_last);
          chk("rsp_error_hold", W'(rsp_error), W'(m_last_err));
        end
        case (m_ph)
          PH_IDLE: if (p >= 0) begin
            m_a = req_a[p*W +: W];
            m_b = req_b[p*W +: W];
            m_m = req_m[p*W +: W];
            e.idx = p;
            e.res = core_fn(m_a, m_b, m_m);
            sb.push_back(e);
            m_ptr = (p + 1) % N;
            m_ph  = PH_START;
          end
          PH_START: begin
            m_ph = PH_WAIT;
            m_wd = 0;
          end
          PH_WAIT: begin
            if (core_done) begin
              m_to = 1'b0;
              m_ph = PH_RESP;
            end else if (m_wd == TO) begin
              m_to = 1'b1;
              m_ph = PH_RESP;
            end else begin
              m_wd++;
            end
          end
          PH_RESP: m_ph = m_to ? PH_FAULT : PH_IDLE;
          default: ;
        endcase
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m);
    req_valid[i] = 1'b1;
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_m[i*W +: W] = m;
  endtask

  // One cycle: observe handshakes mid-cycle, retire accepted requests after the edge.
  task automatic step();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (hs[i]) begin
        req_valid[i] = 1'b0;
        order_log.push_back(i);
      end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!(req_valid == '0 && sb.size() == 0 && m_ph == PH_IDLE)) begin
      if (n >= budget) begin
        fail_now(name);
        return;
      end
      step();
      n++;
    end
  endtask

  task automatic chk_order(input string name, input string exp);
    string s = "";
    foreach (order_log[k]) s = {s, $sformatf("%0d", order_log[k])};
    checks++;
    if (s != exp) begin
      failures++;
      $display("FAIL %s: grant order got '%s' expected '%s'", name, s, exp);
    end
    order_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("async_outputs", W'({req_ready, rsp_valid, rsp_error, busy, fault, core_start}), '0);
    chk("async_core_a", core_a, '0);
    chk("async_rsp_result", rsp_result, '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    order_log.delete();
  endtask

  initial begin : stimulus
    int n;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_m = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Single request from requester 2, 384-cycle core.
    lat_cfg = 384;
    set_req(2, W'(3), W'(5), W'(7));
    drain("t1_drain", 600);
    chk("t1_rsp_result", rsp_result, W'(32'h1F));
    chk("t1_rsp_error", W'(rsp_error), '0);
    chk_order("t1_order", "2");

    // All four requesters valid from reset.
    do_reset();
    lat_cfg = 0;
    for (int i = 0; i < N; i++) set_req(i, rand_w(), rand_w(), rand_w());
    drain("t2_drain", 400);
    chk_order("t2_order", "0123");

    // Fairness: serve 1, then 0 and 1 together -> 0 wins.
    set_req(1, rand_w(), rand_w(), rand_w());
    drain("t3a_drain", 100);
    set_req(0, rand_w(), rand_w(), rand_w());
    set_req(1, rand_w(), rand_w(), rand_w());
    drain("t3b_drain", 200);
    chk_order("t3_order", "101");

    // Spurious done in IDLE and in START.
    spur_now = 1'b1;
    repeat (3) step();
    spur_start = 1'b1;
    set_req(3, rand_w(), rand_w(), rand_w());
    drain("t4_drain", 100);
    chk_order("t4_order", "3");

    // Random traffic with drops and spurious dones.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, rand_w(), rand_w(), rand_w());
        else if (req_valid[i] && $urandom_range(0, 19) == 0)
          req_valid[i] = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) spur_now = 1'b1;
      step();
    end
    drain("t5_drain", 3000);
    order_log.delete();

    // Reset 50 cycles into WAIT, then rr pointer back at 0.
    lat_cfg = 384;
    set_req(1, rand_w(), rand_w(), rand_w());
    n = 0;
    while (m_ph != PH_WAIT && n < 20) begin
      step();
      n++;
    end
    if (m_ph != PH_WAIT) fail_now("t6_reach_wait");
    repeat (50) step();
    do_reset();
    lat_cfg = 0;
    set_req(3, rand_w(), rand_w(), rand_w());
    set_req(0, rand_w(), rand_w(), rand_w());
    drain("t6_drain", 200);
    chk_order("t6_order", "03");

    // Watchdog timeout -> error response, then sticky fault.
    lat_cfg = -1;
    set_req(2, rand_w(), rand_w(), rand_w());
    n = 0;
    while (m_ph != PH_FAULT && n < TO + 20) begin
      step();
      n++;
    end
    if (m_ph != PH_FAULT) fail_now("t7_reach_fault");
    chk("t7_rsp_error", W'(rsp_error), W'(1));
    chk("t7_rsp_result", rsp_result, '0);
    for (int i = 0; i < N; i++) set_req(i, rand_w(), rand_w(), rand_w());
    repeat (100) step();
    chk("t7_fault_sticky", W'(fault), W'(1));
    chk("t7_no_ready", W'(req_ready), '0);
    do_reset();
    chk("t7_fault_cleared", W'(fault), '0);
    lat_cfg = 0;
    set_req(0, rand_w(), rand_w(), rand_w());
    drain("t7_drain", 100);
    chk_order("t7_order", "0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : global_guard
    #2_000_000;
    fail_now("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
